// File: rtl/alu_pkg.sv
// Shared ALU control encodings and checker state type.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } chk_state_t;

  // Carry and overflow only carry meaning for the adder ops.
  function automatic logic flags_checked(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference ALU: expected result and flags for one operand/op set.
module alu_golden_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] exp_result,
  output logic             exp_cout,
  output logic             exp_ovf,
  output logic             exp_zero,
  output logic             legal
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [WIDTH-1:0] b_eff;
  logic        [WIDTH:0]   sum_ext;
  logic                    sub;

  assign a_s = a;
  assign b_s = b;

  // SUB is formed as a + ~b + 1 so both adder ops share one carry/overflow rule.
  always_comb begin
    sub        = (op == OP_SUB);
    b_eff      = sub ? ~b : b;
    sum_ext    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    exp_result = '0;
    exp_cout   = 1'b0;
    exp_ovf    = 1'b0;
    legal      = 1'b1;
    case (op)
      OP_AND: exp_result = a & b;
      OP_OR:  exp_result = a | b;
      OP_NOR: exp_result = ~(a | b);
      OP_ADD, OP_SUB: begin
        exp_result = sum_ext[WIDTH-1:0];
        exp_cout   = sum_ext[WIDTH];
        exp_ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: exp_result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: legal = 1'b0;
    endcase
    exp_zero = (exp_result == '0);
  end

endmodule

// File: rtl/alu_result_checker.sv
// Two-stage ALU result checker: stage 1 registers the transaction with its golden
// values, stage 2 compares and updates saturating counters and first-failure capture.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] result,
  input  logic             cout,
  input  logic             overflow,
  input  logic             zero,
  output logic [CNT_W-1:0] cnt_pass,
  output logic [CNT_W-1:0] cnt_fail,
  output logic [CNT_W-1:0] cnt_illegal,
  output logic             err,
  output logic             halted,
  output logic [CNT_W-1:0] ff_idx,
  output logic [3:0]       ff_op,
  output logic [WIDTH-1:0] ff_exp,
  output logic [WIDTH-1:0] ff_got
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  chk_state_t state, state_nxt;
  logic             rdy;
  logic             accept;
  logic [CNT_W-1:0] idx;

  logic [WIDTH-1:0] g_result;
  logic             g_cout, g_ovf, g_zero, g_legal;

  logic             vld_p1;
  logic             legal_p1, chk_flags_p1;
  logic [3:0]       op_p1;
  logic [CNT_W-1:0] idx_p1;
  logic [WIDTH-1:0] exp_result_p1, result_p1;
  logic             exp_cout_p1, exp_ovf_p1, exp_zero_p1;
  logic             cout_p1, ovf_p1, zero_p1;

  logic             mismatch_p1, pass_p1, fail_p1, ill_p1, stop_now;

  alu_golden_model #(.WIDTH(WIDTH)) u_golden (
    .a          (a),
    .b          (b),
    .op         (op),
    .exp_result (g_result),
    .exp_cout   (g_cout),
    .exp_ovf    (g_ovf),
    .exp_zero   (g_zero),
    .legal      (g_legal)
  );

  // Stage 2 compare, evaluated on the stage-1 registers.
  always_comb begin
    mismatch_p1 = (result_p1 != exp_result_p1) || (zero_p1 != exp_zero_p1) ||
                  (chk_flags_p1 && ((cout_p1 != exp_cout_p1) || (ovf_p1 != exp_ovf_p1)));
    pass_p1  = vld_p1 & legal_p1 & ~mismatch_p1;
    fail_p1  = vld_p1 & legal_p1 & mismatch_p1;
    ill_p1   = vld_p1 & ~legal_p1;
    stop_now = STOP_ON_FAIL && fail_p1;
    in_ready = rdy && (state == RUN) && !clr && !stop_now;
    accept   = in_valid && in_ready;
  end

  // Next state: clr always returns to RUN; a stopping mismatch parks in HALT.
  always_comb begin
    state_nxt = state;
    if (clr)                         state_nxt = RUN;
    else if (state == RUN && stop_now) state_nxt = HALT;
  end

  assign halted = (state == HALT);

  // Control state: FSM, ready, index, stage-1 valid, counters and failure capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      rdy         <= 1'b0;
      idx         <= '0;
      vld_p1      <= 1'b0;
      cnt_pass    <= '0;
      cnt_fail    <= '0;
      cnt_illegal <= '0;
      err         <= 1'b0;
      ff_idx      <= '0;
      ff_op       <= '0;
      ff_exp      <= '0;
      ff_got      <= '0;
    end else if (clr) begin
      state       <= RUN;
      rdy         <= 1'b1;
      idx         <= '0;
      vld_p1      <= 1'b0;
      cnt_pass    <= '0;
      cnt_fail    <= '0;
      cnt_illegal <= '0;
      err         <= 1'b0;
      ff_idx      <= '0;
      ff_op       <= '0;
      ff_exp      <= '0;
      ff_got      <= '0;
    end else begin
      state  <= state_nxt;
      rdy    <= 1'b1;
      vld_p1 <= accept;
      if (accept)  idx         <= idx + 1'b1;
      if (pass_p1) cnt_pass    <= sat_inc(cnt_pass);
      if (ill_p1)  cnt_illegal <= sat_inc(cnt_illegal);
      if (fail_p1) begin
        cnt_fail <= sat_inc(cnt_fail);
        err      <= 1'b1;
        if (!err) begin
          ff_idx <= idx_p1;
          ff_op  <= op_p1;
          ff_exp <= exp_result_p1;
          ff_got <= result_p1;
        end
      end
    end
  end

  // ---- stage 1: capture transaction and golden values on accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      legal_p1      <= g_legal;
      chk_flags_p1  <= flags_checked(op);
      op_p1         <= op;
      idx_p1        <= idx;
      exp_result_p1 <= g_result;
      exp_cout_p1   <= g_cout;
      exp_ovf_p1    <= g_ovf;
      exp_zero_p1   <= g_zero;
      result_p1     <= result;
      cout_p1       <= cout;
      ovf_p1        <= overflow;
      zero_p1       <= zero;
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: halting, non-halting and narrow-counter instances.
module tb_alu_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0, b = '0, result = '0;
  logic [3:0]  op = '0;
  logic        cout = 1'b0, overflow = 1'b0, zero = 1'b0;

  logic        rdy0, err0, halted0;
  logic [15:0] pass0, fail0, ill0, ffidx0;
  logic [3:0]  ffop0;
  logic [31:0] ffexp0, ffgot0;

  logic        rdy1, err1, halted1;
  logic [15:0] pass1, fail1, ill1, ffidx1;
  logic [3:0]  ffop1;
  logic [31:0] ffexp1, ffgot1;

  logic        rdy2, err2, halted2;
  logic [3:0]  pass2, fail2, ill2, ffidx2;
  logic [3:0]  ffop2;
  logic [31:0] ffexp2, ffgot2;

  int n_chk = 0;
  int n_ok  = 0;

  always #5 clk = ~clk;

  alu_result_checker #(.WIDTH(32), .CNT_W(16), .STOP_ON_FAIL(1'b1)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .op(op), .result(result), .cout(cout), .overflow(overflow), .zero(zero),
    .cnt_pass(pass0), .cnt_fail(fail0), .cnt_illegal(ill0), .err(err0), .halted(halted0),
    .ff_idx(ffidx0), .ff_op(ffop0), .ff_exp(ffexp0), .ff_got(ffgot0));

  alu_result_checker #(.WIDTH(32), .CNT_W(16), .STOP_ON_FAIL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .op(op), .result(result), .cout(cout), .overflow(overflow), .zero(zero),
    .cnt_pass(pass1), .cnt_fail(fail1), .cnt_illegal(ill1), .err(err1), .halted(halted1),
    .ff_idx(ffidx1), .ff_op(ffop1), .ff_exp(ffexp1), .ff_got(ffgot1));

  alu_result_checker #(.WIDTH(32), .CNT_W(4), .STOP_ON_FAIL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
    .a(a), .b(b), .op(op), .result(result), .cout(cout), .overflow(overflow), .zero(zero),
    .cnt_pass(pass2), .cnt_fail(fail2), .cnt_illegal(ill2), .err(err2), .halted(halted2),
    .ff_idx(ffidx2), .ff_op(ffop2), .ff_exp(ffexp2), .ff_got(ffgot2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] xr, input logic xc, input logic xv, input logic xz);
    @(negedge clk);
    op = o; a = xa; b = xb; result = xr;
    cout = xc; overflow = xv; zero = xz;
    in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", rdy0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_halted", halted0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", rdy0, 1);

    // 1: ADD signed overflow
    drive(4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("t1_pass", pass0, 1);
    chk("t1_fail", fail0, 0);

    // 2: SUB equal operands, then wrong zero flag halts dut0
    do_clr();
    drive(4'b0110, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b1);
    drive(4'b0110, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("t2_pass", pass0, 1);
    chk("t2_fail", fail0, 1);
    chk("t2_err", err0, 1);
    chk("t2_ffidx", ffidx0, 1);
    chk("t2_ffexp", ffexp0, 0);
    chk("t2_ffop", ffop0, 4'b0110);
    chk("t2_halted", halted0, 1);
    chk("t2_ready", rdy0, 0);
    drive(4'b0010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t2_halt_no_count", pass0, 1);

    // 3: ten back-to-back, 3rd and 7th corrupted
    do_clr();
    chk("t3_clr_halt", halted0, 0);
    for (int i = 0; i < 10; i++)
      drive(4'b0010, i, 32'h1, (i == 2 || i == 6) ? 32'hDEAD : i + 1, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t3_pass", pass1, 8);
    chk("t3_fail", fail1, 2);
    chk("t3_ffidx", ffidx1, 2);
    chk("t3_ffexp", ffexp1, 3);
    chk("t3_ffgot", ffgot1, 32'hDEAD);
    chk("t3_nohalt", halted1, 0);
    chk("t3_stop_pass", pass0, 2);
    chk("t3_stop_fail", fail0, 1);

    // 4: SLT, unchecked flags, logic ops, SUB overflow, illegal op, flag mismatch
    drive(4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    drive(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1, 1'b1, 1'b0);
    drive(4'b0001, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(4'b1100, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(4'b0110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    drive(4'b1111, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0);
    drive(4'b0010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("t4_pass", pass1, 13);
    chk("t4_fail", fail1, 3);
    chk("t4_illegal", ill1, 1);
    chk("t4_ffidx_kept", ffidx1, 2);

    // 5: clr with accept pending and two transactions in flight
    drive(4'b0010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    drive(4'b0010, 32'h2, 32'h2, 32'h4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    op = 4'b0010; a = 32'h3; b = 32'h3; result = 32'h6; in_valid = 1'b1;
    clr = 1'b1;
    #1;
    chk("t5_ready_clr", rdy1, 0);
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    chk("t5_pass0", pass1, 0);
    chk("t5_err0", err1, 0);
    idle(2);
    chk("t5_pass_later", pass1, 0);
    chk("t5_fail_later", fail1, 0);
    chk("t5_ill_later", ill1, 0);

    // 5b: asynchronous reset mid-stream
    drive(4'b0010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    drive(4'b0010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t5b_pre", pass1, 2);
    drive(4'b0010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5b_async_pass", pass1, 0);
    chk("t5b_async_ready", rdy1, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(2);
    chk("t5b_discard", pass1, 0);
    chk("t5b_ready", rdy1, 1);

    // 6: saturation and index wrap on the 4-bit instance
    do_clr();
    for (int i = 0; i < 14; i++) drive(4'b0010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t6_pass14", pass2, 14);
    for (int i = 0; i < 3; i++) drive(4'b0010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t6_sat", pass2, 15);
    drive(4'b0010, 32'h1, 32'h1, 32'h5, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t6_fail", fail2, 1);
    chk("t6_ffidx_wrap", ffidx2, 1);
    chk("t6_sat_hold", pass2, 15);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
